fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus F/D pipeline register of the 5-stage MIPS pipeline.
- Owns the PC. Drives the instruction-memory address and captures the fetched word. Feeds IR, PC+4, PC+8, delay-slot flag and fetch exception code to the decode stage.
- Takes its next-PC decision from decode (npc_sel / npc_d), from the hazard unit (stall), and from CP0 (interrupt / eret / epc).

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- stall  in  1  hazard unit: hold PC and F/D.
- npc_sel  in  1  decode: instruction in D is branch/jump; take npc_d.
- npc_d  in  32  decode's computed next PC.
- interrupt  in  1  CP0 request: redirect to EXC_ENTRY.
- eret  in  1  eret in D: redirect to epc.
- epc  in  32  CP0 EPC.
- im_addr  out  32  instruction-memory address (= pc_F), combinational read.
- im_rdata  in  32  instruction word at im_addr, same cycle.
- pc_F  out  32  current fetch PC.
- IR_D  out  32  instruction to decode.
- PC4_D  out  32  PC of IR_D + 4.
- PC8_D  out  32  PC of IR_D + 8.
- pc_D  out  32  PC of IR_D (EPC source).
- bd_D  out  1  IR_D sits in a branch delay slot.
- exc_D  out  5  fetch exception code for IR_D (0 none, 4 AdEL).

Behaviour:
- Reset (async, reset==0):
  - pc_F = PC_RESET.
  - IR_D, PC4_D, PC8_D, pc_D = 0; bd_D = 0; exc_D = 0.
  - Deassertion is sampled at the next rising edge; the first fetch is 0x3000.
- Next-PC priority, evaluated each rising edge:
  1. interrupt → pc_F <= EXC_ENTRY.
  2. eret → pc_F <= epc.
  3. stall → pc_F holds.
  4. npc_sel → pc_F <= npc_d.
  5. otherwise pc_F <= pc_F + 4, 32-bit wrap, no carry out.
- F/D register, same priority order:
  - interrupt or eret: flush. IR_D <= 0 (nop), bd_D <= 0, exc_D <= 0, PC4_D/PC8_D/pc_D <= 0. Flush beats stall.
  - stall: all F/D outputs hold.
  - Advance: pc_D <= pc_F; PC4_D <= pc_F+4; PC8_D <= pc_F+8; bd_D <= npc_sel (word leaving F is the delay slot of the D branch/jump).
  - Advance, fetch legal: IR_D <= im_rdata, exc_D <= 0.
  - Advance, fetch illegal (pc_F[1:0]!=0, pc_F<IM_LO, or pc_F>IM_HI): IR_D <= 0, exc_D <= 4; pc_D still records the bad pc_F.
- Latency: the word at pc_F appears on IR_D one cycle later. A branch resolved in D takes effect the next edge; the delay slot always executes, with no squash.
- im_addr is purely combinational from pc_F and is never gated.
- Simultaneous interrupt+eret: interrupt wins.
- Simultaneous stall+npc_sel: stall wins; the branch re-evaluates next cycle.
- An illegal PC is still fetched-over; redirection comes only via interrupt from CP0.

Decomposition:
- Shared package mips_defs holds:
  - PC_RESET, EXC_ENTRY, IM_LO, IM_HI.
  - EXC_NONE=5'd0, EXC_ADEL=5'd4.
  - NOP=32'h0.
- One natural sub-module, fd_reg: the F/D register with flush/stall/advance controls, reused later for D/E and E/M.
- fetch_stage contains the PC register, next-PC mux, legality check and an fd_reg instance.

Test Plan:
- Reset low mid-run, then high → pc_F=0x3000. The next edge gives IR_D=im[0x3000], PC4_D=0x3004, PC8_D=0x3008, pc_D=0x3000.
- Free run with no controls for 4 edges → pc_F steps 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; IR_D tracks one cycle behind.
- stall=1 for 2 cycles at pc_F=0x3008 → pc_F and all F/D outputs unchanged; on release, IR_D=im[0x3008].
- npc_sel=1, npc_d=0x3100 while pc_F=0x3010 → next edge: pc_F=0x3100, IR_D=im[0x3010], bd_D=1. Following edge: bd_D=0.
- interrupt=1 together with stall=1 → pc_F=0x4180, IR_D=0, bd_D=0, exc_D=0.
- eret=1, epc=0x3002 → pc_F=0x3002. Next edge: IR_D=0, exc_D=4, pc_D=0x3002. Repeat with epc=0x7000 → exc_D=4.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS pipeline: address map, exception codes
// and the payload carried by the F/D pipeline register.
package mips_defs;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    localparam logic [31:0] NOP       = 32'h0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
    } fd_payload_t;

    localparam int FD_WIDTH = $bits(fd_payload_t);

    // All-zero payload is a nop with no exception, used on flush and reset
    function automatic fd_payload_t fd_bubble();
        fd_payload_t b;
        b     = '0;
        b.ir  = NOP;
        b.exc = EXC_NONE;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// Generic pipeline register with flush (clears to zero) taking priority over
// stall (hold); reused for the later pipeline boundaries.
module fd_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, selects the next PC from CP0/hazard/decode requests,
// checks fetch legality and loads the F/D register.
module fetch_stage
    import mips_defs::*;
#(
    parameter logic [31:0] P_PC_RESET  = PC_RESET,
    parameter logic [31:0] P_EXC_ENTRY = EXC_ENTRY,
    parameter logic [31:0] P_IM_LO     = IM_LO,
    parameter logic [31:0] P_IM_HI     = IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_d,
    input  logic        interrupt,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic [31:0] pc_D,
    output logic        bd_D,
    output logic [4:0]  exc_D
);

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        fetch_ok;
    logic        flush;
    fd_payload_t fd_d;
    fd_payload_t fd_q;
    logic [FD_WIDTH-1:0] fd_q_bits;

    assign pc_plus4 = pc_F + 32'd4;
    assign im_addr  = pc_F;
    assign flush    = interrupt | eret;

    assign fetch_ok = (pc_F[1:0] == 2'b00) && (pc_F >= P_IM_LO) && (pc_F <= P_IM_HI);

    // CP0 redirects outrank the hazard stall, which in turn outranks a branch
    always_comb begin
        pc_next = pc_plus4;
        if (interrupt) begin
            pc_next = P_EXC_ENTRY;
        end else if (eret) begin
            pc_next = epc;
        end else if (stall) begin
            pc_next = pc_F;
        end else if (npc_sel) begin
            pc_next = npc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F <= P_PC_RESET;
        end else begin
            pc_F <= pc_next;
        end
    end

    // An illegal fetch still records its PC so CP0 can report the bad address
    always_comb begin
        fd_d     = fd_bubble();
        fd_d.pc4 = pc_plus4;
        fd_d.pc8 = pc_F + 32'd8;
        fd_d.pc  = pc_F;
        fd_d.bd  = npc_sel;
        if (fetch_ok) begin
            fd_d.ir  = im_rdata;
            fd_d.exc = EXC_NONE;
        end else begin
            fd_d.ir  = NOP;
            fd_d.exc = EXC_ADEL;
        end
    end

    fd_reg #(
        .WIDTH (FD_WIDTH)
    ) u_fd_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .stall (stall),
        .d     (fd_d),
        .q     (fd_q_bits)
    );

    assign fd_q  = fd_payload_t'(fd_q_bits);
    assign IR_D  = fd_q.ir;
    assign PC4_D = fd_q.pc4;
    assign PC8_D = fd_q.pc8;
    assign pc_D  = fd_q.pc;
    assign bd_D  = fd_q.bd;
    assign exc_D = fd_q.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a synthetic instruction memory returns an
// address-derived word so every IR_D value can be predicted by hand.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        npc_sel;
    logic [31:0] npc_d;
    logic        interrupt;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] pc_F;
    logic [31:0] IR_D;
    logic [31:0] PC4_D;
    logic [31:0] PC8_D;
    logic [31:0] pc_D;
    logic        bd_D;
    logic [4:0]  exc_D;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .npc_d     (npc_d),
        .interrupt (interrupt),
        .eret      (eret),
        .epc       (epc),
        .im_addr   (im_addr),
        .im_rdata  (im_rdata),
        .pc_F      (pc_F),
        .IR_D      (IR_D),
        .PC4_D     (PC4_D),
        .PC8_D     (PC8_D),
        .pc_D      (pc_D),
        .bd_D      (bd_D),
        .exc_D     (exc_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign im_rdata = im_word(im_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one set of controls, then sample 1ns after the following rising edge
    task automatic applyStimulus(input logic s, input logic ns, input logic [31:0] nd,
                                 input logic irq, input logic er, input logic [31:0] ep);
        stall     = s;
        npc_sel   = ns;
        npc_d     = nd;
        interrupt = irq;
        eret      = er;
        epc       = ep;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFd(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                           input logic bd, input logic [4:0] exc);
        checkOutput({tag, ".IR_D"},  IR_D, ir);
        checkOutput({tag, ".pc_D"},  pc_D, pc);
        checkOutput({tag, ".bd_D"},  {31'd0, bd_D}, {31'd0, bd});
        checkOutput({tag, ".exc_D"}, {27'd0, exc_D}, {27'd0, exc});
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0; npc_sel = 1'b0; npc_d = '0;
        interrupt = 1'b0; eret = 1'b0; epc = '0;
        #12;
        checkOutput("rst.pc_F", pc_F, 32'h3000);
        checkOutput("rst.im_addr", im_addr, 32'h3000);
        checkFd("rst", 32'h0, 32'h0, 1'b0, 5'd0);
        checkOutput("rst.PC4_D", PC4_D, 32'h0);
        reset = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("run0.pc_F", pc_F, 32'h3004);
        checkFd("run0", im_word(32'h3000), 32'h3000, 1'b0, 5'd0);
        checkOutput("run0.PC4_D", PC4_D, 32'h3004);
        checkOutput("run0.PC8_D", PC8_D, 32'h3008);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("run1.pc_F", pc_F, 32'h3008);

        // Reset asserted mid-run acts immediately, released before the next edge
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst.pc_F", pc_F, 32'h3000);
        checkFd("midrst", 32'h0, 32'h0, 1'b0, 5'd0);
        reset = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("free1.pc_F", pc_F, 32'h3004);
        checkFd("free1", im_word(32'h3000), 32'h3000, 1'b0, 5'd0);
        checkOutput("free1.PC8_D", PC8_D, 32'h3008);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("free2.pc_F", pc_F, 32'h3008);
        checkFd("free2", im_word(32'h3004), 32'h3004, 1'b0, 5'd0);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput("stall.pc_F", pc_F, 32'h3008);
            checkFd("stall", im_word(32'h3004), 32'h3004, 1'b0, 5'd0);
            checkOutput("stall.PC4_D", PC4_D, 32'h3008);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("unstall.pc_F", pc_F, 32'h300C);
        checkFd("unstall", im_word(32'h3008), 32'h3008, 1'b0, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("free3.pc_F", pc_F, 32'h3010);

        applyStimulus(0, 1, 32'h3100, 0, 0, 0);
        checkOutput("br.pc_F", pc_F, 32'h3100);
        checkFd("br", im_word(32'h3010), 32'h3010, 1'b1, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("br1.pc_F", pc_F, 32'h3104);
        checkFd("br1", im_word(32'h3100), 32'h3100, 1'b0, 5'd0);

        applyStimulus(1, 1, 32'h3200, 0, 0, 0);
        checkOutput("stallbr.pc_F", pc_F, 32'h3104);
        checkFd("stallbr", im_word(32'h3100), 32'h3100, 1'b0, 5'd0);
        applyStimulus(0, 1, 32'h3200, 0, 0, 0);
        checkOutput("stallbr1.pc_F", pc_F, 32'h3200);
        checkFd("stallbr1", im_word(32'h3104), 32'h3104, 1'b1, 5'd0);

        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("irq.pc_F", pc_F, 32'h4180);
        checkFd("irq", 32'h0, 32'h0, 1'b0, 5'd0);
        checkOutput("irq.PC4_D", PC4_D, 32'h0);

        applyStimulus(0, 0, 0, 1, 1, 32'h3500);
        checkOutput("irqeret.pc_F", pc_F, 32'h4180);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("exc.pc_F", pc_F, 32'h4184);
        checkFd("exc", im_word(32'h4180), 32'h4180, 1'b0, 5'd0);

        applyStimulus(1, 0, 0, 0, 1, 32'h3002);
        checkOutput("eret.pc_F", pc_F, 32'h3002);
        checkFd("eret", 32'h0, 32'h0, 1'b0, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("misal.pc_F", pc_F, 32'h3006);
        checkFd("misal", 32'h0, 32'h3002, 1'b0, 5'd4);
        checkOutput("misal.PC4_D", PC4_D, 32'h3006);

        applyStimulus(0, 0, 0, 0, 1, 32'h7000);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("hi.pc_F", pc_F, 32'h7004);
        checkFd("hi", 32'h0, 32'h7000, 1'b0, 5'd4);

        applyStimulus(0, 0, 0, 0, 1, 32'h6FFC);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkFd("top", im_word(32'h6FFC), 32'h6FFC, 1'b0, 5'd0);
        checkOutput("top.pc_F", pc_F, 32'h7000);

        applyStimulus(0, 0, 0, 0, 1, 32'h2FFC);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkFd("lo", 32'h0, 32'h2FFC, 1'b0, 5'd4);

        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap.pc_F", pc_F, 32'h0);
        checkOutput("wrap.PC4_D", PC4_D, 32'h0);
        checkOutput("wrap.PC8_D", PC8_D, 32'h4);
        checkFd("wrap", 32'h0, 32'hFFFF_FFFC, 1'b0, 5'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
